// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one synchronous-read RAM port between the CPU (port 0) and the loader (port 1).
// Ports:
//   clk_i, rst_ni                        clock, asynchronous active-low reset
//   reqN_i, weN_i, addrN_i, wdataN_i     requester N command, held until gntN_o
//   gntN_o                               command accepted this cycle (combinational)
//   doneN_o                              one-cycle completion pulse
//   rdataN_o                             last read data returned to port N
//   ram_we_o, ram_addr_o, ram_wdata_o    RAM command, driven during the access cycle
//   ram_rdata_i                          RAM read data, one cycle after the address
module ram_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  output logic              gnt0_o,
  output logic              done0_o,
  output logic [DATA_W-1:0] rdata0_o,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt1_o,
  output logic              done1_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  logic [1:0]        state_q, state_d;
  logic              last_q, id_q, we_q, ram_we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rd0_q, rd1_q;
  logic              accept, pick1, gnt, resp;
  // A tie goes to the port that did not win last time, unless port 0 has fixed priority.
  assign accept  = rst_ni && state_q != ACCESS;
  assign pick1   = req1_i && (!req0_i || (FIXED_PRIO == 0 && !last_q));
  assign gnt1_o  = accept && pick1;
  assign gnt0_o  = accept && req0_i && !pick1;
  assign gnt     = gnt0_o || gnt1_o;
  assign resp    = state_q == RESP;
  assign done0_o = resp && !id_q;
  assign done1_o = resp && id_q;
  // Read data is forwarded during the done pulse and captured so it holds afterwards.
  assign rdata0_o    = (done0_o && !we_q) ? ram_rdata_i : rd0_q;
  assign rdata1_o    = (done1_o && !we_q) ? ram_rdata_i : rd1_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;
  always_comb begin
    state_d = state_q == ACCESS ? RESP : gnt ? ACCESS : IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      id_q     <= 1'b0;
      we_q     <= 1'b0;
      ram_we_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd0_q    <= '0;
      rd1_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd0_q    <= rdata0_o;
      rd1_q    <= rdata1_o;
      ram_we_q <= gnt && (gnt1_o ? we1_i : we0_i);
      if (gnt) begin
        last_q  <= gnt1_o;
        id_q    <= gnt1_o;
        we_q    <= gnt1_o ? we1_i : we0_i;
        addr_q  <= gnt1_o ? addr1_i : addr0_i;
        wdata_q <= gnt1_o ? wdata1_i : wdata0_i;
      end
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: checks round-robin and fixed-priority arbiters against directed vectors and a transaction model.
module tb_ram_port_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0] gnt0, gnt1, done0, done1, ram_we;
  logic [1:0][AW-1:0] ram_addr;
  logic [1:0][DW-1:0] ram_wdata, ram_rd, rdata0, rdata1;
  logic [DW-1:0] mem_a [2**AW];
  logic [DW-1:0] mem_b [2**AW];
  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) u_rr (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
    .gnt0_o(gnt0[0]), .done0_o(done0[0]), .rdata0_o(rdata0[0]),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
    .gnt1_o(gnt1[0]), .done1_o(done1[0]), .rdata1_o(rdata1[0]),
    .ram_we_o(ram_we[0]), .ram_addr_o(ram_addr[0]), .ram_wdata_o(ram_wdata[0]),
    .ram_rdata_i(ram_rd[0]));
  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) u_fp (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
    .gnt0_o(gnt0[1]), .done0_o(done0[1]), .rdata0_o(rdata0[1]),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
    .gnt1_o(gnt1[1]), .done1_o(done1[1]), .rdata1_o(rdata1[1]),
    .ram_we_o(ram_we[1]), .ram_addr_o(ram_addr[1]), .ram_wdata_o(ram_wdata[1]),
    .ram_rdata_i(ram_rd[1]));
  always @(posedge clk) begin
    if (ram_we[0]) mem_a[ram_addr[0]] <= ram_wdata[0];
    if (ram_we[1]) mem_b[ram_addr[1]] <= ram_wdata[1];
    ram_rd[0] <= mem_a[ram_addr[0]];
    ram_rd[1] <= mem_b[ram_addr[1]];
  end
  int cyc, checks, errors;
  int m_free [2];
  logic m_last [2];
  logic p_v [2];
  logic p_port [2];
  logic p_we [2];
  int p_cyc [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wd [2];
  logic [DW-1:0] m_rd [2][2];
  logic [DW-1:0] mm [2][2**AW];
  typedef struct {
    logic r0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic r1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic g0, g1, dn0, dn1, rwe; logic [DW-1:0] rd0, rd1;
  } vec_t;
  vec_t tab [12];
  function automatic vec_t v(input logic r0, w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                             input logic r1, w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                             input logic g0, g1, dn0, dn1, rwe, input logic [DW-1:0] rd0, rd1);
    vec_t t;
    t.r0 = r0; t.w0 = w0; t.a0 = a0; t.d0 = d0;
    t.r1 = r1; t.w1 = w1; t.a1 = a1; t.d1 = d1;
    t.g0 = g0; t.g1 = g1; t.dn0 = dn0; t.dn1 = dn1; t.rwe = rwe; t.rd0 = rd0; t.rd1 = rd1;
    return t;
  endfunction
  task automatic chk(input string n, input logic [DW-1:0] a, input logic [DW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_free[d] = 0; m_last[d] = 1'b1; p_v[d] = 1'b0;
      m_rd[d][0] = '0; m_rd[d][1] = '0;
    end
  endtask
  // Transaction-level reference: a grant opens a two-cycle slot; the command completes two cycles later.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      logic acc, w1, e0, e1, dn, acs;
      acc = cyc >= m_free[d];
      w1  = req1 && (!req0 || (d == 0 && !m_last[d]));
      e1  = acc && w1;
      e0  = acc && req0 && !w1;
      dn  = p_v[d] && cyc == p_cyc[d] + 2;
      acs = p_v[d] && cyc == p_cyc[d] + 1;
      if (dn && p_we[d]) mm[d][p_addr[d]] = p_wd[d];
      if (dn && !p_we[d]) m_rd[d][p_port[d]] = mm[d][p_addr[d]];
      chk($sformatf("gnt0[%0d]", d), gnt0[d], e0);
      chk($sformatf("gnt1[%0d]", d), gnt1[d], e1);
      chk($sformatf("done0[%0d]", d), done0[d], dn && !p_port[d]);
      chk($sformatf("done1[%0d]", d), done1[d], dn && p_port[d]);
      chk($sformatf("rdata0[%0d]", d), rdata0[d], m_rd[d][0]);
      chk($sformatf("rdata1[%0d]", d), rdata1[d], m_rd[d][1]);
      chk($sformatf("ram_we[%0d]", d), ram_we[d], acs && p_we[d]);
      if (acs) chk($sformatf("ram_addr[%0d]", d), ram_addr[d], p_addr[d]);
      if (acs && p_we[d]) chk($sformatf("ram_wdata[%0d]", d), ram_wdata[d], p_wd[d]);
      if (dn) p_v[d] = 1'b0;
      if (e0 || e1) begin
        p_v[d] = 1'b1; p_cyc[d] = cyc; p_port[d] = e1;
        p_we[d] = e1 ? we1 : we0;
        p_addr[d] = e1 ? addr1 : addr0;
        p_wd[d] = e1 ? wdata1 : wdata0;
        m_free[d] = cyc + 2;
        m_last[d] = e1;
      end
    end
  endtask
  task automatic adv();
    model_step();
    @(posedge clk);
    cyc++;
    #1;
  endtask
  task automatic tick();
    @(negedge clk);
    adv();
  endtask
  task automatic idle_inputs();
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
  endtask
  task automatic reset_outputs_chk(input string n);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s gnt0[%0d]", n, d), gnt0[d], 0);
      chk($sformatf("%s gnt1[%0d]", n, d), gnt1[d], 0);
      chk($sformatf("%s done0[%0d]", n, d), done0[d], 0);
      chk($sformatf("%s done1[%0d]", n, d), done1[d], 0);
      chk($sformatf("%s ram_we[%0d]", n, d), ram_we[d], 0);
      chk($sformatf("%s ram_addr[%0d]", n, d), ram_addr[d], 0);
      chk($sformatf("%s ram_wdata[%0d]", n, d), ram_wdata[d], 0);
      chk($sformatf("%s rdata0[%0d]", n, d), rdata0[d], 0);
      chk($sformatf("%s rdata1[%0d]", n, d), rdata1[d], 0);
    end
  endtask
  initial begin
    int n_rr, n_fp0, n_fp1;
    logic prev;
    cyc = 0; checks = 0; errors = 0;
    for (int i = 0; i < 2**AW; i++) begin
      mem_a[i] = '0; mem_b[i] = '0; mm[0][i] = '0; mm[1][i] = '0;
    end
    mem_a[16] = 32'hDEADBEEF; mem_b[16] = 32'hDEADBEEF;
    mm[0][16] = 32'hDEADBEEF; mm[1][16] = 32'hDEADBEEF;
    tab[0]  = v(1,0,14'h010,0, 0,0,0,0,            1,0,0,0,0, 0,0);
    tab[1]  = v(0,0,0,0,       0,0,0,0,            0,0,0,0,0, 0,0);
    tab[2]  = v(0,0,0,0,       0,0,0,0,            0,0,1,0,0, 32'hDEADBEEF,0);
    tab[3]  = v(0,0,0,0,       0,0,0,0,            0,0,0,0,0, 32'hDEADBEEF,0);
    tab[4]  = v(0,0,0,0,       1,1,14'h200,32'h12345678, 0,1,0,0,0, 32'hDEADBEEF,0);
    tab[5]  = v(0,0,0,0,       0,0,0,0,            0,0,0,0,1, 32'hDEADBEEF,0);
    tab[6]  = v(0,0,0,0,       0,0,0,0,            0,0,0,1,0, 32'hDEADBEEF,0);
    tab[7]  = v(0,0,0,0,       1,0,14'h200,0,      0,1,0,0,0, 32'hDEADBEEF,0);
    tab[8]  = v(0,0,0,0,       0,0,0,0,            0,0,0,0,0, 32'hDEADBEEF,0);
    tab[9]  = v(1,0,14'h200,0, 0,0,0,0,            1,0,0,1,0, 32'hDEADBEEF,32'h12345678);
    tab[10] = v(0,0,0,0,       0,0,0,0,            0,0,0,0,0, 32'hDEADBEEF,32'h12345678);
    tab[11] = v(0,0,0,0,       0,0,0,0,            0,0,1,0,0, 32'h12345678,32'h12345678);
    rst_n = 0;
    idle_inputs();
    req0 = 1; req1 = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_outputs_chk("reset");
    idle_inputs();
    rst_n = 1;
    for (int i = 0; i < 12; i++) begin
      req0 = tab[i].r0; we0 = tab[i].w0; addr0 = tab[i].a0; wdata0 = tab[i].d0;
      req1 = tab[i].r1; we1 = tab[i].w1; addr1 = tab[i].a1; wdata1 = tab[i].d1;
      @(negedge clk);
      chk($sformatf("tab%0d gnt0", i), gnt0[0], tab[i].g0);
      chk($sformatf("tab%0d gnt1", i), gnt1[0], tab[i].g1);
      chk($sformatf("tab%0d done0", i), done0[0], tab[i].dn0);
      chk($sformatf("tab%0d done1", i), done1[0], tab[i].dn1);
      chk($sformatf("tab%0d ram_we", i), ram_we[0], tab[i].rwe);
      chk($sformatf("tab%0d rdata0", i), rdata0[0], tab[i].rd0);
      chk($sformatf("tab%0d rdata1", i), rdata1[0], tab[i].rd1);
      if (i == 1) chk("tab1 ram_addr", ram_addr[0], 14'h010);
      adv();
    end
    req0 = 1; addr0 = 14'h001; req1 = 1; addr1 = 14'h002;
    n_rr = 0; n_fp0 = 0; n_fp1 = 0; prev = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (gnt0[0] || gnt1[0]) begin
        if (n_rr > 0) chk("rr alternate", gnt1[0], !prev);
        prev = gnt1[0];
        n_rr++;
      end
      n_fp0 += int'(gnt0[1]);
      n_fp1 += int'(gnt1[1]);
      adv();
    end
    chk("rr grants in 16", n_rr, 8);
    chk("fp gnt0 count", n_fp0, 8);
    chk("fp gnt1 count", n_fp1, 0);
    req0 = 0;
    @(negedge clk);
    chk("fp gnt1 after drop", gnt1[1], 1);
    adv();
    idle_inputs();
    repeat (3) tick();
    for (int i = 0; i < 400; i++) begin
      req0 = 1'($urandom_range(0, 1)); we0 = 1'($urandom_range(0, 1));
      addr0 = AW'($urandom_range(0, 15)); wdata0 = $urandom;
      req1 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
      addr1 = AW'($urandom_range(0, 15)); wdata1 = $urandom;
      tick();
    end
    idle_inputs();
    repeat (3) tick();
    req0 = 1; we0 = 1; addr0 = 14'h005; wdata0 = 32'hA5A5A5A5;
    @(negedge clk);
    chk("mid gnt0 rr", gnt0[0], 1);
    chk("mid gnt0 fp", gnt0[1], 1);
    adv();
    chk("mid access ram_we rr", ram_we[0], 1);
    chk("mid access ram_we fp", ram_we[1], 1);
    #1;
    rst_n = 0;
    #1;
    reset_outputs_chk("async");
    model_reset();
    @(posedge clk); cyc++;
    #1;
    reset_outputs_chk("held");
    @(posedge clk); cyc++;
    #3;
    rst_n = 1;
    req0 = 1; we0 = 0; addr0 = 14'h005; req1 = 1; we1 = 0; addr1 = 14'h006;
    @(negedge clk);
    chk("post reset tie rr", gnt0[0], 1);
    chk("post reset tie fp", gnt0[1], 1);
    adv();
    idle_inputs();
    repeat (3) tick();
    req0 = 1; addr0 = 14'h003;
    tick();
    req0 = 0; req1 = 1; addr1 = 14'h004;
    @(negedge clk);
    chk("withdraw gnt1 rr", gnt1[0], 0);
    chk("withdraw gnt1 fp", gnt1[1], 0);
    adv();
    req1 = 0;
    tick();
    req0 = 1; req1 = 1;
    @(negedge clk);
    chk("after withdraw tie rr", gnt1[0], 1);
    chk("after withdraw tie fp", gnt0[1], 1);
    adv();
    idle_inputs();
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares the single data-RAM port between two requesters: port 0 is the CPU load/store path and port 1 is the program/data loader (DMA-style initialiser). The block accepts one transaction at a time, sequences it through the synchronous-read RAM, and returns a completion pulse with read data to the winner. It sits between the LoadStoreUnit / loader and the RAM instance.

Parameters:
ADDR_W, 14, RAM word-address width.
DATA_W, 32, data width.
FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins ties.

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  asynchronous, active-low reset
req0  in  1  port 0 request; held until gnt0
we0  in  1  port 0 write (1) / read (0)
addr0  in  ADDR_W  port 0 word address
wdata0  in  DATA_W  port 0 write data
gnt0  out  1  port 0 command accepted this cycle
done0  out  1  port 0 transaction complete (one-cycle pulse)
rdata0  out  DATA_W  port 0 read data, valid when done0 and read
req1, we1, addr1, wdata1, gnt1, done1, rdata1: same as port 0 for port 1
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address (read and write)
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid one cycle after address presented

Behaviour:
- States: IDLE, ACCESS, RESP. Reset (rst low, asynchronous): state = IDLE, last_gnt = 1, latched cmd regs = 0, and ram_we = 0, done0/1 = 0, ram_addr = 0, ram_wdata = 0, rdata0/1 = 0.
- Acceptance is allowed in IDLE or RESP ("accept window"). gnt0/gnt1 are combinational in the accept window, at most one high, and 0 in ACCESS and while rst is low.
- Winner selection: only one req, that port wins. Both req: with FIXED_PRIO = 1, port 0 wins. With FIXED_PRIO = 0, the port not equal to last_gnt wins.
- Posedge with gnt: latch winner id, we, addr and wdata. Update last_gnt to the winner. Go to ACCESS.
- ACCESS (exactly 1 cycle): ram_addr = latched addr, ram_wdata = latched wdata, ram_we = latched we. Next state is RESP.
- RESP (1 cycle):
  - done<winner> = 1 for both reads and writes.
  - rdata<winner> = ram_rdata for reads; the other port's rdata is held.
  - ram_we = 0.
  - If a new gnt is issued in this cycle, go to ACCESS; otherwise go to IDLE.
- Outputs:
  - rdata0/1 are registered copies that hold the last read value until the next read completion on that port.
  - ram_addr holds its last value outside ACCESS.
  - ram_we is high only in ACCESS.
- Latency: gnt at cycle N, ram access at N+1, done at N+2. Back-to-back throughput is one transaction every 2 cycles.
- A req dropped before gnt is legal and is ignored. The command inputs are sampled only on the gnt edge; later changes do not affect the transaction in flight.
- Reset mid-ACCESS: ram_we falls immediately, no done is issued, and the transaction is lost; the requester must re-issue it.
- Address and data pass through unmodified; there is no wrap or width conversion.

Test Plan:
- Reset then single read: RAM[0x0010] = 0xDEADBEEF; req0 = 1, we0 = 0, addr0 = 0x0010 → gnt0 in cycle 0, ram_addr = 0x0010 and ram_we = 0 in cycle 1, done0 = 1 with rdata0 = 0xDEADBEEF in cycle 2, state IDLE in cycle 3.
- Write then readback: port 1 writes 0x12345678 to 0x0200 (ram_we = 1 for exactly 1 cycle, done1 at +2); port 1 then reads 0x0200 → rdata1 = 0x12345678; rdata0 unchanged.
- Contention, FIXED_PRIO = 0: both ports hold req from reset → grant order 0, 1, 0, 1, with a gnt every 2 cycles and gnt issued in RESP; 8 transactions complete in 16 cycles.
- Contention, FIXED_PRIO = 1: both ports hold req → port 0 granted every time, gnt1 never asserted until req0 drops; then gnt1 in the next accept window.
- Reset mid-ACCESS: write issued by port 0, rst pulled low asynchronously during ACCESS → ram_we drops the same cycle, no done0, all outputs at reset values; after release, the first tie grants port 0.
- Request withdrawal: req1 pulsed during ACCESS of port 0 and dropped before RESP → gnt1 never asserted, no port 1 transaction, last_gnt = 0.
